// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, forwarding-source order,
// and the ID hold-buffer state encoding.
package cpu_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_NUM_FWD = 3;
  localparam int DEF_CNT_W   = 16;

  // Forwarding sources, youngest (highest priority) first.
  // Source i sits at bits [i*W +: W] of the packed buses.
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HELD = 1'b1
  } hold_st_e;

endpackage

// File: rtl/id_fwd_resolve.sv
// Priority forwarding match for one source operand; r0 always reads 0.
// pend flags a winning producer whose result is not ready yet.
module id_fwd_resolve
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]         rf_rdata_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_ready_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      pend_o
);

  logic hit;

  always_comb begin
    data_o = rf_rdata_i;
    pend_o = 1'b0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_we_i[i] &&
          fwd_waddr_i[i*REG_AW +: REG_AW] == addr_i) begin
        hit    = 1'b1;
        data_o = fwd_wdata_i[i*DATA_W +: DATA_W];
        pend_o = ~fwd_ready_i[i];
      end
    end
    if (addr_i == '0) begin
      data_o = '0;
      pend_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID front end: IF/ID register, instruction hold buffer,
// operand forwarding, load-use stall and stall-cycle counter.
module id_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      stall_ext,
  input  logic                      if_valid,
  input  logic [PC_W-1:0]           if_pc,
  input  logic [DATA_W-1:0]         inst_rdata,
  input  logic                      use_rs,
  input  logic                      use_rt,
  output logic [REG_AW-1:0]         rf_raddr1,
  output logic [REG_AW-1:0]         rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  output logic                      id_valid,
  output logic [PC_W-1:0]           id_pc,
  output logic [DATA_W-1:0]         id_inst,
  output logic [DATA_W-1:0]         src1_data,
  output logic [DATA_W-1:0]         src2_data,
  output logic                      stallreq_id,
  output logic [CNT_W-1:0]          hazard_cnt
);

  hold_st_e          state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              advance;
  logic              pend_rs, pend_rt;

  assign advance = ~stall_ext & ~stallreq_id;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_LIVE;
      hold_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_LIVE: begin
        if (!advance && !flush) begin
          hold_d  = inst_rdata;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (advance || flush) state_d = ST_LIVE;
      end
      default: state_d = ST_LIVE;
    endcase
  end

  // The held word masks SRAM read data changing under a stall.
  always_comb begin
    unique case (state_q)
      ST_HELD: id_inst = hold_q;
      default: id_inst = inst_rdata;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    unique case (1'b1)
      flush: valid_d = 1'b0;
      advance: begin
        valid_d = if_valid;
        pc_d    = if_pc;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stallreq_id && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  assign rf_raddr1 = id_inst[25:21];
  assign rf_raddr2 = id_inst[20:16];

  id_fwd_resolve #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .NUM_FWD(NUM_FWD)
  ) u_rs (
    .addr_i     (rf_raddr1),
    .rf_rdata_i (rf_rdata1),
    .fwd_we_i   (fwd_we),
    .fwd_waddr_i(fwd_waddr),
    .fwd_wdata_i(fwd_wdata),
    .fwd_ready_i(fwd_ready),
    .data_o     (src1_data),
    .pend_o     (pend_rs)
  );

  id_fwd_resolve #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .NUM_FWD(NUM_FWD)
  ) u_rt (
    .addr_i     (rf_raddr2),
    .rf_rdata_i (rf_rdata2),
    .fwd_we_i   (fwd_we),
    .fwd_waddr_i(fwd_waddr),
    .fwd_wdata_i(fwd_wdata),
    .fwd_ready_i(fwd_ready),
    .data_o     (src2_data),
    .pend_o     (pend_rt)
  );

  assign stallreq_id = valid_q & ((use_rs & pend_rs) | (use_rt & pend_rt));
  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign hazard_cnt  = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: expectations queued by the
// stimulus, compared by a negedge monitor.
module tb_id_operand_stage;

  localparam int CW = 3;

  localparam int O_VALID = 0;
  localparam int O_PC    = 1;
  localparam int O_INST  = 2;
  localparam int O_SRC1  = 3;
  localparam int O_SRC2  = 4;
  localparam int O_STALL = 5;
  localparam int O_CNT   = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush, stall_ext, if_valid;
  logic [31:0] if_pc, inst_rdata;
  logic        use_rs, use_rt;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [2:0]  fwd_we, fwd_ready;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic        id_valid;
  logic [31:0] id_pc, id_inst, src1_data, src2_data;
  logic        stallreq_id;
  logic [CW-1:0] hazard_cnt;

  id_operand_stage #(.CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall_ext(stall_ext),
    .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
    .use_rs(use_rs), .use_rt(use_rt),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_ready(fwd_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .src1_data(src1_data), .src2_data(src2_data),
    .stallreq_id(stallreq_id), .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          o;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  function automatic logic [31:0] mk(input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {6'h0, rs, rt, 16'h0};
  endfunction

  function automatic logic [31:0] sel(input int o);
    case (o)
      O_VALID: return {31'h0, id_valid};
      O_PC:    return id_pc;
      O_INST:  return id_inst;
      O_SRC1:  return src1_data;
      O_SRC2:  return src2_data;
      O_STALL: return {31'h0, stallreq_id};
      default: return {{(32-CW){1'b0}}, hazard_cnt};
    endcase
  endfunction

  task automatic chk(input string n, input int o, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.o    = o;
    e.v    = v;
    sb.push_back(e);
  endtask

  task automatic set_fwd(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic rdy);
    fwd_we[i]             = we;
    fwd_waddr[i*5 +: 5]   = a;
    fwd_wdata[i*32 +: 32] = d;
    fwd_ready[i]          = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = sel(e.o);
      n_cmp++;
      if (act !== e.v) begin
        n_mis++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; stall_ext = 1'b0; if_valid = 1'b0;
    if_pc = '0; inst_rdata = 32'hA5A5_0000;
    use_rs = 1'b0; use_rt = 1'b0; rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_ready = '1;
    tick();
    chk("rst_valid", O_VALID, 0);
    chk("rst_pc", O_PC, 0);
    chk("rst_stall", O_STALL, 0);
    chk("rst_cnt", O_CNT, 0);
    chk("rst_inst", O_INST, 32'hA5A5_0000);
    tick();
    resetn = 1'b1; if_valid = 1'b1; if_pc = 32'h100;
    inst_rdata = mk(5, 0); use_rs = 1'b1;
    rf_rdata1 = 32'h1234; rf_rdata2 = 32'h5678;
    set_fwd(0, 1, 5, 32'h11, 1);
    set_fwd(1, 1, 5, 32'h22, 1);
    chk("pre_valid", O_VALID, 0);
    chk("prio_ex", O_SRC1, 32'h11);
    tick();
    fwd_we[0] = 1'b0; if_pc = 32'h104;
    chk("adv_valid", O_VALID, 1);
    chk("adv_pc", O_PC, 32'h100);
    chk("prio_mem", O_SRC1, 32'h22);
    tick();
    fwd_we = '0; if_pc = 32'h108;
    chk("pc_104", O_PC, 32'h104);
    chk("rf_path", O_SRC1, 32'h1234);
    tick();
    inst_rdata = mk(0, 0); if_pc = 32'h10C;
    set_fwd(0, 1, 0, 32'hFFFF_FFFF, 1);
    chk("r0_src1", O_SRC1, 0);
    chk("r0_src2", O_SRC2, 0);
    tick();
    inst_rdata = mk(7, 9); if_pc = 32'h110;
    fwd_we = '0;
    set_fwd(2, 1, 9, 32'h99, 1);
    chk("wb_src2", O_SRC2, 32'h99);
    chk("wb_src1_rf", O_SRC1, 32'h1234);
    tick();
    inst_rdata = mk(0, 8); if_pc = 32'h200;
    use_rs = 1'b0; use_rt = 1'b0;
    fwd_we = '0;
    set_fwd(0, 1, 8, 32'h80, 0);
    chk("unused_nostall", O_STALL, 0);
    chk("unused_src2", O_SRC2, 32'h80);
    chk("pc_110", O_PC, 32'h110);
    tick();
    use_rt = 1'b1; if_pc = 32'h204;
    set_fwd(0, 1, 8, 32'hAA, 1);
    set_fwd(1, 1, 8, 32'hBB, 0);
    chk("lowprio_ignored", O_STALL, 0);
    chk("lowprio_src2", O_SRC2, 32'hAA);
    chk("pc_200", O_PC, 32'h200);
    tick();
    fwd_we = '0; if_pc = 32'h208;
    set_fwd(0, 1, 8, 32'hCAFE, 0);
    chk("lu_stall", O_STALL, 1);
    chk("lu_pc", O_PC, 32'h204);
    chk("lu_cnt0", O_CNT, 0);
    tick();
    inst_rdata = 32'hFFFF_FFFF;
    chk("lu_stall2", O_STALL, 1);
    chk("lu_pc_held", O_PC, 32'h204);
    chk("lu_cnt1", O_CNT, 1);
    chk("lu_inst_held", O_INST, mk(0, 8));
    tick();
    fwd_ready[0] = 1'b1;
    chk("lu_release", O_STALL, 0);
    chk("lu_src2", O_SRC2, 32'hCAFE);
    chk("lu_cnt2", O_CNT, 2);
    tick();
    inst_rdata = 32'h3C01_0001; use_rt = 1'b0; fwd_we = '0;
    if_pc = 32'h300; stall_ext = 1'b1;
    chk("lu_adv_pc", O_PC, 32'h208);
    chk("hold_live", O_INST, 32'h3C01_0001);
    tick();
    for (int k = 0; k < 3; k++) begin
      inst_rdata = 32'hDEAD_BEEF;
      stall_ext = (k < 2);
      chk("hold_inst", O_INST, 32'h3C01_0001);
      chk("hold_pc", O_PC, 32'h208);
      tick();
    end
    inst_rdata = 32'h1234_5678;
    chk("rel_inst", O_INST, 32'h1234_5678);
    chk("rel_pc", O_PC, 32'h300);
    tick();
    stall_ext = 1'b1; inst_rdata = 32'h0C0C_0C0C;
    tick();
    flush = 1'b1; inst_rdata = 32'h1111_2222;
    chk("fl_inst_held", O_INST, 32'h0C0C_0C0C);
    chk("fl_valid_pre", O_VALID, 1);
    tick();
    flush = 1'b0; inst_rdata = mk(0, 8); use_rt = 1'b1;
    set_fwd(0, 1, 8, 32'hCAFE, 0);
    chk("fl_valid", O_VALID, 0);
    chk("fl_live", O_INST, mk(0, 8));
    chk("fl_nostall", O_STALL, 0);
    chk("fl_pc", O_PC, 32'h300);
    chk("fl_cnt", O_CNT, 2);
    tick();
    stall_ext = 1'b0; if_pc = 32'h400;
    chk("fl_nostall2", O_STALL, 0);
    tick();
    chk("ar_stall", O_STALL, 1);
    chk("ar_pc", O_PC, 32'h400);
    tick();
    inst_rdata = 32'hFFFF_FFFF;
    chk("ar_held", O_INST, mk(0, 8));
    chk("ar_cnt3", O_CNT, 3);
    tick();
    resetn = 1'b0;
    chk("ar_valid", O_VALID, 0);
    chk("ar_pc0", O_PC, 0);
    chk("ar_stall0", O_STALL, 0);
    chk("ar_cnt0", O_CNT, 0);
    chk("ar_live", O_INST, 32'hFFFF_FFFF);
    tick();
    resetn = 1'b1; inst_rdata = 32'h55AA_55AA;
    chk("post_rst_live", O_INST, 32'h55AA_55AA);
    tick();
    inst_rdata = mk(0, 8);
    for (int k = 0; k < 10; k++) begin
      chk("sat_stall", O_STALL, 1);
      chk("sat_cnt", O_CNT, (k < 7) ? k : 7);
      tick();
    end
    fwd_ready[0] = 1'b1;
    chk("sat_release", O_STALL, 0);
    chk("sat_hold", O_CNT, 7);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d queued expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
